// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words, writes them
// to consecutive instruction-memory addresses and holds the core in reset until done.
module program_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] lenWords,
  input  logic        inValid,
  input  logic [7:0]  inData,
  output logic        inReady,
  output logic        imemWrite,
  output logic [31:0] imemAddress,
  output logic [31:0] imemWriteData,
  output logic        coreReset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wordIdx_q, wordIdx_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        inReady_q, imemWrite_q, coreReset_q, busy_q, done_q, error_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordIdx_d = wordIdx_q;
    byteCnt_d = byteCnt_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d     = lenWords;
          wordIdx_d = 16'd0;
          byteCnt_d = 2'd0;
          if (lenWords == 16'd0)
            state_d = DONE;
          else if ({16'd0, lenWords} > DEPTH_WORDS)
            state_d = ERROR;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (inValid) begin
          case (byteCnt_q)
            2'd0: word_d[7:0]   = inData;
            2'd1: word_d[15:8]  = inData;
            2'd2: word_d[23:16] = inData;
            default: begin
              // The fourth byte goes straight into the write data register
              data_d  = {inData, word_q};
              addr_d  = BASE_ADDR + {14'd0, wordIdx_q, 2'b00};
              state_d = WRITE;
            end
          endcase
          byteCnt_d = byteCnt_q + 2'd1;
        end
      end
      WRITE: begin
        if (wordIdx_q + 16'd1 == len_q) begin
          state_d = DONE;
        end else begin
          wordIdx_d = wordIdx_q + 16'd1;
          state_d   = LOAD;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // reflect the state entered at this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      wordIdx_q   <= 16'd0;
      byteCnt_q   <= 2'd0;
      word_q      <= 24'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      inReady_q   <= 1'b0;
      imemWrite_q <= 1'b0;
      coreReset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wordIdx_q   <= wordIdx_d;
      byteCnt_q   <= byteCnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      inReady_q   <= (state_d == LOAD);
      imemWrite_q <= (state_d == WRITE);
      coreReset_q <= (state_d == DONE);
      busy_q      <= (state_d == LOAD) || (state_d == WRITE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERROR);
    end
  end

  assign inReady       = inReady_q;
  assign imemWrite     = imemWrite_q;
  assign imemAddress   = addr_q;
  assign imemWriteData = data_q;
  assign coreReset     = coreReset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as each word
// is driven and matched against every imemWrite strobe.
module tb_program_loader;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] lenWords;
  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        imemWrite;
  logic [31:0] imemAddress;
  logic [31:0] imemWriteData;
  logic        coreReset;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  program_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start), .lenWords(lenWords),
    .inValid(inValid), .inData(inData), .inReady(inReady),
    .imemWrite(imemWrite), .imemAddress(imemAddress),
    .imemWriteData(imemWriteData), .coreReset(coreReset),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imemWrite === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr %h data %h, no write expected", imemAddress, imemWriteData);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (imemAddress !== e.addr || imemWriteData !== e.data) begin
          errors++;
          $display("[TB] FAIL write: got addr %h data %h, expected addr %h data %h",
                   imemAddress, imemWriteData, e.addr, e.data);
        end
      end
    end
  end

  task automatic expectFlags(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {inReady, imemWrite, coreReset, busy, done, error};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: flags {inReady,imemWrite,coreReset,busy,done,error} got %b expected %b", name, got, exp);
    end
  endtask

  task automatic expectResetState(input string name);
    checks++;
    if ({inReady, imemWrite, coreReset, busy, done, error} !== 6'b0 ||
        imemAddress !== 32'd0 || imemWriteData !== 32'd0) begin
      errors++;
      $display("[TB] FAIL %s: flags %b addr %h data %h, expected all zero", name,
               {inReady, imemWrite, coreReset, busy, done, error}, imemAddress, imemWriteData);
    end
  endtask

  task automatic startLoad(input logic [15:0] len);
    start    = 1'b1;
    lenWords = len;
    @(negedge clk);
    start    = 1'b0;
    lenWords = 16'hFFFF;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt;
    waitCnt = 0;
    repeat (gap) begin
      inValid = 1'b0;
      @(negedge clk);
      checks++;
      if (inReady !== 1'b1 || imemWrite !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall: inReady %b imemWrite %b, expected 1 and 0", inReady, imemWrite);
      end
    end
    while (inReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: inReady %b, expected 1", inReady);
    end
    inValid = 1'b1;
    inData  = b;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], gap);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    expectResetState("reset_values");
    reset = 1'b1;
    @(negedge clk);
    expectResetState("idle_after_reset");
  endtask

  task automatic test_zero_len;
    startLoad(16'd0);
    expectFlags("zero_len_done", 6'b001010);
  endtask

  task automatic test_back_to_back;
    time t0;
    expQ.push_back('{32'h0, 32'h0000_0013});
    expQ.push_back('{32'h4, 32'h0010_0093});
    startLoad(16'd2);
    t0 = $time;
    expectFlags("two_word_loading", 6'b100100);
    sendWord(32'h0000_0013, 0);
    sendWord(32'h0010_0093, 0);
    expectFlags("two_word_write", 6'b010100);
    @(negedge clk);
    expectFlags("two_word_done", 6'b001010);
    checks++;
    if ($time - t0 != 100) begin
      errors++;
      $display("[TB] FAIL throughput: got %0t ns, expected 100 ns", $time - t0);
    end
  endtask

  task automatic test_stall_reload;
    expQ.push_back('{32'h0, 32'hDEAD_BEEF});
    startLoad(16'd1);
    expectFlags("reload_core_in_reset", 6'b100100);
    sendWord(32'hDEAD_BEEF, 3);
    @(negedge clk);
    expectFlags("stall_done", 6'b001010);
  endtask

  task automatic test_full_depth;
    logic [31:0] w[4];
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      expQ.push_back('{32'(4 * i), w[i]});
    end
    startLoad(16'(DEPTH));
    for (int i = 0; i < 4; i++) sendWord(w[i], 0);
    @(negedge clk);
    expectFlags("full_depth_done", 6'b001010);
  endtask

  task automatic test_reset_midload;
    expQ.push_back('{32'h0, 32'h1122_3344});
    startLoad(16'd2);
    sendWord(32'h1122_3344, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    reset = 1'b0;
    @(negedge clk);
    expectResetState("midload_reset");
    reset = 1'b1;
    expQ.push_back('{32'h0, 32'hCAFE_F00D});
    startLoad(16'd1);
    sendWord(32'hCAFE_F00D, 0);
    @(negedge clk);
    expectFlags("after_reset_reload_done", 6'b001010);
  endtask

  task automatic test_error;
    startLoad(16'(DEPTH + 1));
    expectFlags("error_entered", 6'b000001);
    startLoad(16'd1);
    inValid = 1'b1;
    inData  = 8'h55;
    repeat (3) @(negedge clk);
    inValid = 1'b0;
    expectFlags("error_sticky", 6'b000001);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expectResetState("error_cleared_by_reset");
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    lenWords = 16'd0;
    inValid  = 1'b0;
    inData   = 8'd0;
    test_reset();
    test_zero_len();
    test_back_to_back();
    test_stall_reload();
    test_full_depth();
    test_reset_midload();
    test_error();
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_writes: got %0d outstanding, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
